// File: rtl/pipe_trap_ctrl_pkg.sv
// pipe_trap_ctrl_pkg: shared CSR addresses, cause codes, stall/flush patterns and trap FSM states
package pipe_trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;

    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] CAUSE_IRQ    = 32'h8000_000B;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // stall bits: [0] PC, [1] IF/ID, [2] ID/EXE, [3] EXE/MEM, [4] MEM/WB
    localparam logic [4:0] STALL_PC  = 5'b00001;
    localparam logic [4:0] STALL_ID  = 5'b00011;
    localparam logic [4:0] STALL_EXE = 5'b00111;

    // flush bits: [0] IF/ID, [1] ID/EXE, [2] EXE/MEM
    localparam logic [2:0] FLUSH_ALL   = 3'b111;
    localparam logic [2:0] FLUSH_FRONT = 3'b011;
    localparam logic [2:0] FLUSH_ID    = 3'b010;
    localparam logic [2:0] FLUSH_EXE   = 3'b100;

    typedef enum logic [2:0] {
        IDLE,
        SAVE_EPC,
        SAVE_CAUSE,
        SAVE_STATUS,
        MRET_STATUS,
        REDIRECT
    } trap_state_e;

endpackage

// File: rtl/pipe_trap_ctrl_trap_csr_seq.sv
// trap_csr_seq: trap entry/exit FSM owning the CSR write port and the epc/cause/target registers
module trap_csr_seq
    import pipe_trap_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CSR_AW     = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trap_take,
    input  logic                  mret_take,
    input  logic [DATA_WIDTH-1:0] cause,
    input  logic [ADDR_WIDTH-1:0] epc,
    input  logic [DATA_WIDTH-1:0] mstatus,
    input  logic [DATA_WIDTH-1:0] mepc,
    input  logic [DATA_WIDTH-1:0] mtvec,
    input  logic                  exe_we,
    input  logic [CSR_AW-1:0]     exe_waddr,
    input  logic [DATA_WIDTH-1:0] exe_wdata,
    output logic                  busy,
    output logic [4:0]            stall,
    output logic [2:0]            flush,
    output logic                  redirect,
    output logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  csr_we,
    output logic [CSR_AW-1:0]     csr_waddr,
    output logic [DATA_WIDTH-1:0] csr_wdata
);

    trap_state_e state, next;
    logic [ADDR_WIDTH-1:0] epc_q, target_q;
    logic [DATA_WIDTH-1:0] cause_q;
    logic [DATA_WIDTH-1:0] keep, status_entry, status_mret;

    assign keep         = mstatus & ~((DATA_WIDTH'(1) << MSTATUS_MIE) | (DATA_WIDTH'(1) << MSTATUS_MPIE));
    assign status_entry = keep | (DATA_WIDTH'(mstatus[MSTATUS_MIE]) << MSTATUS_MPIE);
    assign status_mret  = keep | (DATA_WIDTH'(mstatus[MSTATUS_MPIE]) << MSTATUS_MIE) | (DATA_WIDTH'(1) << MSTATUS_MPIE);
    assign busy         = state != IDLE;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    // capture faulting PC and cause on entry; handler or return target before the redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc_q    <= '0;
            cause_q  <= '0;
            target_q <= '0;
        end else begin
            if (state == IDLE && trap_take) begin
                epc_q   <= epc;
                cause_q <= cause;
            end
            if (state == IDLE && mret_take) target_q <= ADDR_WIDTH'(mepc);
            if (state == SAVE_CAUSE) target_q <= ADDR_WIDTH'(mtvec & ~DATA_WIDTH'(3));
        end
    end

    // next state and CSR port mux; EXE writes pass only in IDLE and never for a trapping instruction
    always_comb begin
        next          = state;
        stall         = '0;
        flush         = '0;
        redirect      = 1'b0;
        redirect_addr = '0;
        csr_we        = 1'b0;
        csr_waddr     = '0;
        csr_wdata     = '0;
        case (state)
            IDLE: begin
                csr_we    = exe_we & ~trap_take & ~mret_take;
                csr_waddr = exe_waddr;
                csr_wdata = exe_wdata;
                next      = trap_take ? SAVE_EPC : mret_take ? MRET_STATUS : IDLE;
            end
            SAVE_EPC: begin
                stall     = STALL_PC;
                flush     = FLUSH_FRONT;
                csr_we    = 1'b1;
                csr_waddr = CSR_AW'(CSR_MEPC);
                csr_wdata = DATA_WIDTH'(epc_q);
                next      = SAVE_CAUSE;
            end
            SAVE_CAUSE: begin
                stall     = STALL_PC;
                flush     = FLUSH_FRONT;
                csr_we    = 1'b1;
                csr_waddr = CSR_AW'(CSR_MCAUSE);
                csr_wdata = cause_q;
                next      = SAVE_STATUS;
            end
            SAVE_STATUS: begin
                stall     = STALL_PC;
                flush     = FLUSH_FRONT;
                csr_we    = 1'b1;
                csr_waddr = CSR_AW'(CSR_MSTATUS);
                csr_wdata = status_entry;
                next      = REDIRECT;
            end
            MRET_STATUS: begin
                stall     = STALL_PC;
                flush     = FLUSH_FRONT;
                csr_we    = 1'b1;
                csr_waddr = CSR_AW'(CSR_MSTATUS);
                csr_wdata = status_mret;
                next      = REDIRECT;
            end
            REDIRECT: begin
                flush         = FLUSH_FRONT;
                redirect      = 1'b1;
                redirect_addr = target_q;
                next          = IDLE;
            end
            default: next = IDLE;
        endcase
    end

endmodule

// File: rtl/pipe_trap_ctrl.sv
// pipe_trap_ctrl: pipeline stall/flush/redirect priority and trap-sequence CSR port arbitration
module pipe_trap_ctrl
    import pipe_trap_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CSR_AW     = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_stallreq_i,
    input  logic                  exe_stallreq_i,
    input  logic                  exe_valid_i,
    input  logic [ADDR_WIDTH-1:0] exe_inst_addr_i,
    input  logic                  exe_jump_i,
    input  logic [ADDR_WIDTH-1:0] exe_jump_addr_i,
    input  logic                  exe_ecall_i,
    input  logic                  exe_ebreak_i,
    input  logic                  exe_mret_i,
    input  logic                  irq_i,
    input  logic [DATA_WIDTH-1:0] csr_mstatus_i,
    input  logic [DATA_WIDTH-1:0] csr_mepc_i,
    input  logic [DATA_WIDTH-1:0] csr_mtvec_i,
    input  logic                  exe_csr_we_i,
    input  logic [CSR_AW-1:0]     exe_csr_waddr_i,
    input  logic [DATA_WIDTH-1:0] exe_csr_wdata_i,
    output logic [4:0]            stall_o,
    output logic [2:0]            flush_o,
    output logic                  redirect_o,
    output logic [ADDR_WIDTH-1:0] redirect_addr_o,
    output logic                  csr_we_o,
    output logic [CSR_AW-1:0]     csr_waddr_o,
    output logic [DATA_WIDTH-1:0] csr_wdata_o,
    output logic                  trap_busy_o
);

    logic                  irq_take, trap_take, mret_take, busy;
    logic [DATA_WIDTH-1:0] cause;
    logic [4:0]            prio_stall, seq_stall;
    logic [2:0]            prio_flush, seq_flush;
    logic                  prio_redirect, seq_redirect, seq_we;
    logic [ADDR_WIDTH-1:0] prio_addr, seq_addr;
    logic [CSR_AW-1:0]     seq_waddr;
    logic [DATA_WIDTH-1:0] seq_wdata;

    // an interrupt only squashes a real instruction that is free to leave EXE
    assign irq_take  = irq_i & csr_mstatus_i[MSTATUS_MIE] & exe_valid_i & ~exe_stallreq_i;
    assign trap_take = exe_ecall_i | exe_ebreak_i | irq_take;
    assign mret_take = exe_mret_i & ~trap_take;
    assign cause     = exe_ecall_i  ? DATA_WIDTH'(CAUSE_ECALL)
                     : exe_ebreak_i ? DATA_WIDTH'(CAUSE_EBREAK)
                     :                DATA_WIDTH'(CAUSE_IRQ);

    trap_csr_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CSR_AW     (CSR_AW)
    ) u_seq (
        .clk           (clk_i),
        .rst_n         (rst_i),
        .trap_take     (trap_take),
        .mret_take     (mret_take),
        .cause         (cause),
        .epc           (exe_inst_addr_i),
        .mstatus       (csr_mstatus_i),
        .mepc          (csr_mepc_i),
        .mtvec         (csr_mtvec_i),
        .exe_we        (exe_csr_we_i),
        .exe_waddr     (exe_csr_waddr_i),
        .exe_wdata     (exe_csr_wdata_i),
        .busy          (busy),
        .stall         (seq_stall),
        .flush         (seq_flush),
        .redirect      (seq_redirect),
        .redirect_addr (seq_addr),
        .csr_we        (seq_we),
        .csr_waddr     (seq_waddr),
        .csr_wdata     (seq_wdata)
    );

    // idle-state event priority: trap/mret > jump > EXE stall > ID stall
    always_comb begin
        prio_stall    = '0;
        prio_flush    = '0;
        prio_redirect = 1'b0;
        prio_addr     = '0;
        if (trap_take || mret_take) begin
            prio_stall = STALL_PC;
            prio_flush = FLUSH_ALL;
        end else if (exe_jump_i) begin
            prio_redirect = 1'b1;
            prio_addr     = exe_jump_addr_i;
            prio_flush    = FLUSH_FRONT;
        end else if (exe_stallreq_i) begin
            prio_stall = STALL_EXE;
            prio_flush = FLUSH_EXE;
        end else if (id_stallreq_i) begin
            prio_stall = STALL_ID;
            prio_flush = FLUSH_ID;
        end
    end

    // outputs are held at zero for as long as reset is asserted
    assign stall_o         = rst_i ? (busy ? seq_stall : prio_stall) : '0;
    assign flush_o         = rst_i ? (busy ? seq_flush : prio_flush) : '0;
    assign redirect_o      = rst_i & (busy ? seq_redirect : prio_redirect);
    assign redirect_addr_o = rst_i ? (busy ? seq_addr : prio_addr) : '0;
    assign csr_we_o        = rst_i & seq_we;
    assign csr_waddr_o     = rst_i ? seq_waddr : '0;
    assign csr_wdata_o     = rst_i ? seq_wdata : '0;
    assign trap_busy_o     = busy;

endmodule

// File: tb/tb_pipe_trap_ctrl.sv
// tb_pipe_trap_ctrl: table vectors plus trap/mret/reset sequences checked through a scoreboard queue
module tb_pipe_trap_ctrl;

    typedef struct packed {
        logic        id_st;
        logic        exe_st;
        logic        valid;
        logic [31:0] pc;
        logic        jump;
        logic [31:0] jaddr;
        logic        ecall;
        logic        ebreak;
        logic        mret;
        logic        irq;
        logic [31:0] mstatus;
        logic [31:0] mepc;
        logic [31:0] mtvec;
        logic        cwe;
        logic [11:0] cwaddr;
        logic [31:0] cwdata;
    } in_t;

    typedef struct packed {
        logic [4:0]  stall;
        logic [2:0]  flush;
        logic        redir;
        logic [31:0] raddr;
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        busy;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    in_t         cur = '0;
    logic [4:0]  stall;
    logic [2:0]  flush;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        busy;
    out_t        act;

    out_t  exp_q[$];
    string nm_q[$];
    int    compared = 0;
    int    mismatched = 0;
    vec_t  vecs[11];

    always #5 clk = ~clk;

    assign act = {stall, flush, redirect, redirect_addr, csr_we, csr_waddr, csr_wdata, busy};

    pipe_trap_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .id_stallreq_i   (cur.id_st),
        .exe_stallreq_i  (cur.exe_st),
        .exe_valid_i     (cur.valid),
        .exe_inst_addr_i (cur.pc),
        .exe_jump_i      (cur.jump),
        .exe_jump_addr_i (cur.jaddr),
        .exe_ecall_i     (cur.ecall),
        .exe_ebreak_i    (cur.ebreak),
        .exe_mret_i      (cur.mret),
        .irq_i           (cur.irq),
        .csr_mstatus_i   (cur.mstatus),
        .csr_mepc_i      (cur.mepc),
        .csr_mtvec_i     (cur.mtvec),
        .exe_csr_we_i    (cur.cwe),
        .exe_csr_waddr_i (cur.cwaddr),
        .exe_csr_wdata_i (cur.cwdata),
        .stall_o         (stall),
        .flush_o         (flush),
        .redirect_o      (redirect),
        .redirect_addr_o (redirect_addr),
        .csr_we_o        (csr_we),
        .csr_waddr_o     (csr_waddr),
        .csr_wdata_o     (csr_wdata),
        .trap_busy_o     (busy)
    );

    function automatic in_t mi(logic id_st, logic exe_st, logic valid, logic [31:0] pc, logic jump, logic [31:0] jaddr,
                               logic ecall, logic ebreak, logic mret, logic irq, logic [31:0] mstatus, logic [31:0] mepc,
                               logic [31:0] mtvec, logic cwe, logic [11:0] cwaddr, logic [31:0] cwdata);
        return {id_st, exe_st, valid, pc, jump, jaddr, ecall, ebreak, mret, irq, mstatus, mepc, mtvec, cwe, cwaddr, cwdata};
    endfunction

    function automatic out_t mo(logic [4:0] s, logic [2:0] f, logic r, logic [31:0] ra, logic we, logic [11:0] wa,
                                logic [31:0] wd, logic b);
        return {s, f, r, ra, we, wa, wd, b};
    endfunction

    // CSR address/data only matter when a write is expected, the redirect address only with a redirect
    task automatic check(input bit strict);
        out_t  e, a;
        string n;
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        a = act;
        if (!strict) begin
            if (!e.we) begin
                a.waddr = e.waddr;
                a.wdata = e.wdata;
            end
            if (!e.redir) a.raddr = e.raddr;
        end
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s: got stall=%b flush=%b redir=%b raddr=%h we=%b waddr=%h wdata=%h busy=%b, expected stall=%b flush=%b redir=%b raddr=%h we=%b waddr=%h wdata=%h busy=%b",
                     n, act.stall, act.flush, act.redir, act.raddr, act.we, act.waddr, act.wdata, act.busy,
                     e.stall, e.flush, e.redir, e.raddr, e.we, e.waddr, e.wdata, e.busy);
        end
    endtask

    task automatic drive(input in_t v, input out_t e, input string nm);
        @(posedge clk);
        #1;
        cur = v;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(negedge clk);
        check(1'b0);
    endtask

    task automatic now_check(input out_t e, input string nm);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        #1;
        check(1'b1);
    endtask

    initial begin
        in_t  e0, e1, m0, m1, q0, b0, r0, r1;
        out_t z;
        z = '0;

        vecs[0]  = {mi(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0),                     mo(5'b00000,3'b000,0,0,0,0,0,0)};
        vecs[1]  = {mi(1,0,1,32'h10,0,0,0,0,0,0,0,0,0,0,0,0),                mo(5'b00011,3'b010,0,0,0,0,0,0)};
        vecs[2]  = {mi(0,0,1,32'h14,0,0,0,0,0,0,0,0,0,0,0,0),                mo(5'b00000,3'b000,0,0,0,0,0,0)};
        vecs[3]  = {mi(0,1,1,32'h18,0,0,0,0,0,0,0,0,0,0,0,0),                mo(5'b00111,3'b100,0,0,0,0,0,0)};
        vecs[4]  = {mi(1,1,1,32'h18,0,0,0,0,0,0,0,0,0,0,0,0),                mo(5'b00111,3'b100,0,0,0,0,0,0)};
        vecs[5]  = {mi(0,0,1,32'h1c,1,32'h80,0,0,0,0,0,0,0,0,0,0),           mo(5'b00000,3'b011,1,32'h80,0,0,0,0)};
        vecs[6]  = {mi(1,1,1,32'h1c,1,32'h90,0,0,0,0,0,0,0,0,0,0),           mo(5'b00000,3'b011,1,32'h90,0,0,0,0)};
        vecs[7]  = {mi(0,0,1,32'h24,0,0,0,0,0,0,0,0,0,1,12'h305,32'h1234),   mo(5'b00000,3'b000,0,0,1,12'h305,32'h1234,0)};
        vecs[8]  = {mi(0,0,1,32'h20,1,32'h200,0,0,0,1,32'h0,0,32'h300,0,0,0), mo(5'b00000,3'b011,1,32'h200,0,0,0,0)};
        vecs[9]  = {mi(0,0,0,32'h28,0,0,0,0,0,1,32'h8,0,32'h300,0,0,0),      mo(5'b00000,3'b000,0,0,0,0,0,0)};
        vecs[10] = {mi(1,1,1,32'h2c,0,0,0,0,0,1,32'h8,0,32'h300,1,12'h340,32'h5), mo(5'b00111,3'b100,0,0,1,12'h340,32'h5,0)};

        cur = mi(1,0,1,32'h10,1,32'h80,0,0,0,0,0,0,0,1,12'h340,32'h1);
        #2;
        now_check(z, "reset_outputs");
        @(posedge clk);
        #1;
        now_check(z, "reset_hold");
        rst = 1'b1;
        cur = '0;

        for (int k = 0; k < 11; k++) drive(vecs[k].i, vecs[k].o, $sformatf("vec%0d", k));

        e0 = mi(0,0,1,32'h40,0,0,1,0,0,0,32'h8,0,32'h101,1,12'h340,32'hdead);
        e1 = mi(1,0,1,32'h44,1,32'h500,0,0,0,0,32'h8,0,32'h101,1,12'h340,32'hbeef);
        drive(e0, mo(5'b00001,3'b111,0,0,0,0,0,0),           "ecall_detect");
        drive(e1, mo(5'b00001,3'b011,0,0,1,12'h341,32'h40,1), "ecall_mepc");
        drive(e1, mo(5'b00001,3'b011,0,0,1,12'h342,32'd11,1), "ecall_mcause");
        drive(e1, mo(5'b00001,3'b011,0,0,1,12'h300,32'h80,1), "ecall_mstatus");
        drive(e1, mo(5'b00000,3'b011,1,32'h100,0,0,0,1),     "ecall_redirect");
        drive('0, z,                                         "ecall_done");

        m0 = mi(0,0,1,32'h50,0,0,0,0,1,0,32'h80,32'h44,0,1,12'h340,32'h7);
        m1 = mi(0,0,0,0,0,0,0,0,0,0,32'h80,32'h99,0,1,12'h305,32'h3);
        drive(m0, mo(5'b00001,3'b111,0,0,0,0,0,0),           "mret_detect");
        drive(m1, mo(5'b00001,3'b011,0,0,1,12'h300,32'h88,1), "mret_mstatus");
        drive(m1, mo(5'b00000,3'b011,1,32'h44,0,0,0,1),      "mret_redirect");
        drive('0, z,                                         "mret_done");

        q0 = mi(0,0,1,32'h20,1,32'h300,0,0,0,1,32'h8,0,32'h200,0,0,0);
        drive(q0, mo(5'b00001,3'b111,0,0,0,0,0,0),                  "irq_jump_detect");
        drive(q0, mo(5'b00001,3'b011,0,0,1,12'h341,32'h20,1),        "irq_mepc");
        drive(q0, mo(5'b00001,3'b011,0,0,1,12'h342,32'h8000000b,1),  "irq_mcause");
        drive(q0, mo(5'b00001,3'b011,0,0,1,12'h300,32'h80,1),        "irq_mstatus");
        drive(q0, mo(5'b00000,3'b011,1,32'h200,0,0,0,1),            "irq_redirect");
        drive('0, z,                                                "irq_done");

        b0 = mi(0,0,1,32'h64,0,0,0,1,0,0,32'h0,0,32'h8,0,0,0);
        drive(b0, mo(5'b00001,3'b111,0,0,0,0,0,0),           "ebreak_detect");
        drive(b0, mo(5'b00001,3'b011,0,0,1,12'h341,32'h64,1), "ebreak_mepc");
        drive(b0, mo(5'b00001,3'b011,0,0,1,12'h342,32'd3,1),  "ebreak_mcause");
        drive(b0, mo(5'b00001,3'b011,0,0,1,12'h300,32'h0,1),  "ebreak_mstatus");
        drive(b0, mo(5'b00000,3'b011,1,32'h8,0,0,0,1),       "ebreak_redirect");
        drive('0, z,                                         "ebreak_done");

        r0 = mi(0,0,1,32'h60,0,0,1,0,0,0,32'h8,0,32'h400,0,0,0);
        r1 = mi(1,0,1,32'h64,1,32'h80,0,0,0,0,32'h8,0,32'h400,1,12'h340,32'h9);
        drive(r0, mo(5'b00001,3'b111,0,0,0,0,0,0),           "rst_seq_detect");
        drive(r1, mo(5'b00001,3'b011,0,0,1,12'h341,32'h60,1), "rst_seq_mepc");
        drive(r1, mo(5'b00001,3'b011,0,0,1,12'h342,32'd11,1), "rst_seq_mcause");
        rst = 1'b0;
        now_check(z, "rst_mid_outputs");
        @(posedge clk);
        #1;
        rst = 1'b1;
        cur = '0;
        drive('0, z, "rst_idle");
        drive(vecs[5].i, vecs[5].o, "rst_post_jump");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
